roi_frame_decider: RTL

// - Consumes the camera/VGA pixel stream (Draw_X/Draw_Y + red channel) downstream of the box overlay.
// - Sums red intensity over a fixed ROI per frame, divides by the accepted pixel count, and applies

---
 rtl/roi_frame_decider.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/roi_frame_decider.sv
// Per-frame ROI red-average decider: accumulate, restoring divide, hysteresis + debounce -> MoveSignal.
// Optional ROI_OVERLAY_EN adds a registered RGB pass-through that paints a green band around the ROI.
module roi_frame_decider #(
    parameter int ROI_X0   = 270,
    parameter int ROI_X1   = 370,
    parameter int ROI_Y0   = 160,
    parameter int ROI_Y1   = 320,
    parameter int H_LAST   = 639,
    parameter int V_LAST   = 479,
    parameter int SUM_W    = 24,
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic       Clk,
    input  logic       RST_n,
    input  logic       pix_valid,
    input  logic [9:0] Draw_X,
    input  logic [9:0] Draw_Y,
    input  logic [7:0] oVGA_R,
    input  logic [7:0] thr_hi,
    input  logic [7:0] thr_lo,
`ifdef ROI_OVERLAY_EN
    input  logic [7:0] oVGA_G,
    input  logic [7:0] oVGA_B,
    output logic [7:0] out_R,
    output logic [7:0] out_G,
    output logic [7:0] out_B,
`endif
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic       MoveSignal,
    output logic       overrun
);
    localparam int BW = (SUM_W > 1) ? $clog2(SUM_W) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {ACCUM, DIVIDE, DECIDE} state_t;
    state_t state, state_nxt;

    logic             in_roi, roi_hit, frame_end;
    logic [SUM_W-1:0] sum_acc, snap_sum;
    logic [CNT_W-1:0] cnt_acc, snap_cnt;
    logic [SUM_W-1:0] div_q;
    logic [CNT_W-1:0] div_den, div_rem, diff;
    logic [CNT_W:0]   trial;
    logic             ge, den_zero;
    logic [BW-1:0]    bcnt;
    logic [DW-1:0]    dcnt, dcnt_inc;
    logic [7:0]       avg_calc;
    logic             target;
    logic             load_div, shift_en, decide_en;

    assign in_roi    = (Draw_X >= 10'(ROI_X0)) && (Draw_X < 10'(ROI_X1)) &&
                       (Draw_Y >= 10'(ROI_Y0)) && (Draw_Y < 10'(ROI_Y1));
    assign roi_hit   = pix_valid && in_roi;
    assign frame_end = pix_valid && (Draw_X == 10'(H_LAST)) && (Draw_Y == 10'(V_LAST));

    // The frame-end pixel itself still belongs to the ending frame.
    assign snap_sum = sum_acc + (roi_hit ? SUM_W'(oVGA_R) : SUM_W'(0));
    assign snap_cnt = cnt_acc + (roi_hit ? CNT_W'(1) : CNT_W'(0));

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            sum_acc <= '0;
            cnt_acc <= '0;
        end else if (frame_end) begin
            sum_acc <= '0;
            cnt_acc <= '0;
        end else if (roi_hit) begin
            sum_acc <= snap_sum;
            cnt_acc <= snap_cnt;
        end
    end

    // FSM: state register
    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (frame_end) state_nxt = DIVIDE;
            DIVIDE:  if (bcnt == BW'(SUM_W - 1)) state_nxt = DECIDE;
            DECIDE:  state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        load_div  = 1'b0;
        shift_en  = 1'b0;
        decide_en = 1'b0;
        case (state)
            ACCUM:   load_div  = frame_end;
            DIVIDE:  shift_en  = 1'b1;
            DECIDE:  decide_en = 1'b1;
            default: ;
        endcase
    end

    // Restoring divider: div_q starts as the dividend and shifts into the quotient.
    assign den_zero = (div_den == '0);
    assign trial    = {div_rem, div_q[SUM_W-1]};
    assign ge       = trial >= {1'b0, div_den};
    assign diff     = trial[CNT_W-1:0] - div_den;

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            div_q   <= '0;
            div_den <= '0;
            div_rem <= '0;
            bcnt    <= '0;
        end else if (load_div) begin
            div_q   <= snap_sum;
            div_den <= snap_cnt;
            div_rem <= '0;
            bcnt    <= '0;
        end else if (shift_en) begin
            bcnt <= bcnt + BW'(1);
            if (!den_zero) begin
                div_rem <= ge ? diff : trial[CNT_W-1:0];
                div_q   <= {div_q[SUM_W-2:0], ge};
            end
        end
    end

    assign avg_calc = den_zero            ? 8'd0 :
                      (|div_q[SUM_W-1:8]) ? 8'hFF : div_q[7:0];
    assign target   = (avg_calc >= thr_hi) ? 1'b1 :
                      (avg_calc <  thr_lo) ? 1'b0 : MoveSignal;
    assign dcnt_inc = dcnt + DW'(1);

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            avg_out    <= '0;
            avg_valid  <= 1'b0;
            MoveSignal <= 1'b0;
            dcnt       <= '0;
        end else begin
            avg_valid <= decide_en;
            if (decide_en) begin
                avg_out <= avg_calc;
                if (target != MoveSignal) begin
                    if (dcnt_inc >= DW'(DEBOUNCE)) begin
                        MoveSignal <= ~MoveSignal;
                        dcnt       <= '0;
                    end else begin
                        dcnt <= dcnt_inc;
                    end
                end else begin
                    dcnt <= '0;
                end
            end
        end
    end

    // A frame ending while the divider is busy is lost; flag it until reset.
    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n)                           overrun <= 1'b0;
        else if (frame_end && state != ACCUM) overrun <= 1'b1;
    end

`ifdef ROI_OVERLAY_EN
    logic in_outer, in_band;
    assign in_outer = (Draw_X >= 10'(ROI_X0 - 4)) && (Draw_X <= 10'(ROI_X1 + 3)) &&
                      (Draw_Y >= 10'(ROI_Y0 - 4)) && (Draw_Y <= 10'(ROI_Y1 + 3));
    assign in_band  = in_outer && !in_roi;

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            out_R <= '0;
            out_G <= '0;
            out_B <= '0;
        end else if (in_band) begin
            out_R <= 8'h00;
            out_G <= 8'hFF;
            out_B <= 8'h00;
        end else begin
            out_R <= oVGA_R;
            out_G <= oVGA_G;
            out_B <= oVGA_B;
        end
    end
`endif

endmodule
